// File: rtl/key_scan.sv
// key_scan: 2-FF sync plus per-key debounce FSM for active-low buttons; one-hot press pulse and debounced levels.
// Latency: stable raw low to flag_key = 2 + CNT_MAX + 1 cycles. No backpressure: only the lowest-index event of a cycle survives.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_scan #(
    parameter int KEY_W      = 4,
    parameter int CNT_MAX    = 1000000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_INT = 10000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] flag_key,
    output logic [KEY_W-1:0] key_level,
    output logic             key_busy
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    if (CNT_MAX < 1 || REPEAT_DLY < 1 || REPEAT_INT < 1) begin : g_bad_cfg
        $error("key_scan: timing parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t           state_q [KEY_W];
    state_t           state_d [KEY_W];
    logic [CW-1:0]    cnt_q   [KEY_W];
    logic [CW-1:0]    cnt_d   [KEY_W];
    logic [KEY_W-1:0] sync1, sync2;
    logic [KEY_W-1:0] event_d, level_d, busy_d;

`ifdef KEY_REPEAT_EN
    localparam int HOLD_MAX = (REPEAT_DLY > REPEAT_INT) ? REPEAT_DLY : REPEAT_INT;
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] DLY_LAST = HW'(REPEAT_DLY - 1);
    localparam logic [HW-1:0] INT_LAST = HW'(REPEAT_INT - 1);

    logic [HW-1:0]    hold_q [KEY_W];
    logic [HW-1:0]    hold_d [KEY_W];
    logic [KEY_W-1:0] rep_q, rep_d;
`endif

    always_comb begin
        event_d = '0;
        level_d = '0;
        busy_d  = '0;
`ifdef KEY_REPEAT_EN
        rep_d   = '0;
`endif
        for (int i = 0; i < KEY_W; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;
`ifdef KEY_REPEAT_EN
            hold_d[i]  = '0;
`endif
            case (state_q[i])
                IDLE: begin
                    if (!sync2[i]) state_d[i] = PRESS_DB;
                end
                PRESS_DB: begin
                    // any bounce drops back to IDLE so the window restarts from zero
                    if (sync2[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HELD;
                        event_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                HELD: begin
                    if (sync2[i]) state_d[i] = REL_DB;
`ifdef KEY_REPEAT_EN
                    else begin
                        rep_d[i] = rep_q[i];
                        if (hold_q[i] == (rep_q[i] ? INT_LAST : DLY_LAST)) begin
                            event_d[i] = 1'b1;
                            rep_d[i]   = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + HW'(1);
                        end
                    end
`endif
                end
                REL_DB: begin
                    if (!sync2[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
            level_d[i] = (state_d[i] == HELD) || (state_d[i] == REL_DB);
            busy_d[i]  = (state_d[i] != IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1     <= '1;
            sync2     <= '1;
            flag_key  <= '0;
            key_level <= '0;
            key_busy  <= 1'b0;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
`ifdef KEY_REPEAT_EN
                hold_q[i]  <= '0;
`endif
            end
`ifdef KEY_REPEAT_EN
            rep_q <= '0;
`endif
        end else begin
            sync1     <= key_in;
            sync2     <= sync1;
            // isolate lowest set bit; higher simultaneous events are dropped
            flag_key  <= event_d & (~event_d + KEY_W'(1));
            key_level <= level_d;
            key_busy  <= |busy_d;
            for (int i = 0; i < KEY_W; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
`ifdef KEY_REPEAT_EN
                hold_q[i]  <= hold_d[i];
`endif
            end
`ifdef KEY_REPEAT_EN
            rep_q <= rep_d;
`endif
        end
    end
endmodule

// File: tb/tb_key_scan.sv
// Bench for key_scan: directed scenarios plus random bouncing keys against a run-length debounce model.
module tb_key_scan;
    localparam int CM = 8;
    localparam int RD = 20;
    localparam int RI = 5;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] key_in;
    logic [3:0] flag_key;
    logic [3:0] key_level;
    logic       key_busy;

    key_scan #(.KEY_W(4), .CNT_MAX(CM), .REPEAT_DLY(RD), .REPEAT_INT(RI)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .key_in   (key_in),
        .flag_key (flag_key),
        .key_level(key_level),
        .key_busy (key_busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // model: raw history (2-deep sync), debounced level, run of samples disagreeing with level
    logic [3:0] h1, h2, m_level, m_flag;
    int         run [4];
    int         hc  [4];
    bit         rep [4];

    int         pulse_cnt, pulse_cyc;
    logic [3:0] pulse_val;
    int         t0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        logic [3:0] smp;
        logic [3:0] ev;
        bit         pressed, was_held;
        if (RST) begin
            h1 = '1; h2 = '1; m_level = '0; m_flag = '0;
            for (int i = 0; i < 4; i++) begin run[i] = 0; hc[i] = 0; rep[i] = 0; end
        end else begin
            smp = h2;
            h2  = h1;
            h1  = key_in;
            ev  = '0;
            for (int i = 0; i < 4; i++) begin
                pressed  = !smp[i];
                was_held = m_level[i] && run[i] == 0;
                if (pressed != m_level[i]) begin
                    run[i]++;
                    if (run[i] == CM + 1) begin
                        m_level[i] = pressed;
                        run[i] = 0;
                        if (pressed) ev[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
`ifdef KEY_REPEAT_EN
                if (was_held && pressed) begin
                    hc[i]++;
                    if (hc[i] == (rep[i] ? RI : RD)) begin
                        ev[i] = 1'b1; hc[i] = 0; rep[i] = 1;
                    end
                end else begin
                    hc[i] = 0; rep[i] = 0;
                end
`else
                if (was_held) hc[i] = 0;
`endif
            end
            m_flag = '0;
            for (int i = 0; i < 4; i++)
                if (ev[i] && m_flag == 4'b0) m_flag[i] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        cyc++;
        @(negedge CLK);
        check("flag", flag_key, m_flag);
        check("level", key_level, m_level);
        check("busy", key_busy, (m_level != 0) || run[0] > 0 || run[1] > 0 || run[2] > 0 || run[3] > 0);
        if (flag_key != 4'b0) begin
            pulse_cnt++;
            pulse_cyc = cyc;
            pulse_val = flag_key;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        RST = 1'b1;
        key_in = 4'b1111;
        pulse_cnt = 0; pulse_cyc = -1; pulse_val = '0;
        ticks(3);
        check("rst_flag", flag_key, 4'b0000);
        check("rst_level", key_level, 4'b0000);
        check("rst_busy", key_busy, 1'b0);
        RST = 1'b0;
        ticks(50);
        check("idle_pulses", pulse_cnt, 0);

        // single key press, 11-cycle latency, no repeat
        key_in[2] = 1'b0; t0 = cyc; pulse_cnt = 0;
        ticks(40);
        check("k2_cnt", pulse_cnt, 1);
        check("k2_lat", pulse_cyc - t0, 11);
        check("k2_val", pulse_val, 4'b0100);
        check("k2_level", key_level, 4'b0100);
        key_in[2] = 1'b1; t0 = cyc;
        for (int k = 0; k < 40 && key_level[2]; k++) tick();
        check("k2_rel_lat", cyc - t0, 11);
        ticks(5);

        // bounce restarts the window
        pulse_cnt = 0;
        key_in[0] = 1'b0; ticks(3);
        key_in[0] = 1'b1; ticks(1);
        key_in[0] = 1'b0; t0 = cyc;
        ticks(30);
        check("bnc_cnt", pulse_cnt, 1);
        check("bnc_lat", pulse_cyc - t0, 11);
        check("bnc_val", pulse_val, 4'b0001);
        key_in[0] = 1'b1; ticks(30);

        // simultaneous presses: lowest index wins
        pulse_cnt = 0;
        key_in[1] = 1'b0; key_in[3] = 1'b0;
        ticks(30);
        check("sim_cnt", pulse_cnt, 1);
        check("sim_val", pulse_val, 4'b0010);
        check("sim_level", key_level, 4'b1010);
        key_in = 4'b1111; ticks(30);

        // reset while held, then re-debounce
        key_in[2] = 1'b0; ticks(20);
        RST = 1'b1; ticks(1);
        check("rh_flag", flag_key, 4'b0000);
        check("rh_level", key_level, 4'b0000);
        check("rh_busy", key_busy, 1'b0);
        RST = 1'b0; t0 = cyc; pulse_cnt = 0;
        ticks(30);
        check("rh_cnt", pulse_cnt, 1);
        check("rh_lat", pulse_cyc - t0, 11);
        check("rh_val", pulse_val, 4'b0100);
        key_in = 4'b1111; ticks(30);

        // long hold on key 3
        pulse_cnt = 0;
        key_in[3] = 1'b0;
        ticks(60);
`ifdef KEY_REPEAT_EN
        check("hold_cnt", pulse_cnt, 7);
`else
        check("hold_cnt", pulse_cnt, 1);
`endif
        key_in = 4'b1111; ticks(30);

        // random bouncing with occasional reset
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 11) == 0) key_in[i] = ~key_in[i];
            RST = ($urandom_range(0, 499) == 0);
            tick();
        end
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
